// File: rtl/fir_coeff_ctrl_if.sv
// Host-side coefficient load port for fir_coeff_ctrl: valid/ready word stream plus
// commit and error-clear strobes.
interface fir_coeff_ctrl_if #(
    parameter int unsigned NBT_COEFF = 8
);
    logic                 i_wr_valid;
    logic                 o_wr_ready;
    logic [NBT_COEFF-1:0] i_wr_data;
    logic                 i_wr_last;
    logic                 i_commit;
    logic                 i_err_clr;

    modport master (
        output i_wr_valid, i_wr_data, i_wr_last, i_commit, i_err_clr,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_wr_last, i_commit, i_err_clr,
        output o_wr_ready
    );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// Runtime FIR coefficient controller: loads a shadow bank from the host, then swaps it into
// the active bus while holding the FIR disabled and flushing its delay line.
module fir_coeff_ctrl #(
    parameter int unsigned NUM_COEFF = 17,
    parameter int unsigned NBT_COEFF = 8,
    parameter int unsigned NBF_COEFF = 7
) (
    input  logic                           clk,
    input  logic                           i_reset_n,
    input  logic                           i_en,
    fir_coeff_ctrl_if.slave                host,
    output logic [NUM_COEFF*NBT_COEFF-1:0] o_coeff_bus,
    output logic                           o_fir_en,
    output logic                           o_fir_flush,
    output logic                           o_busy,
    output logic                           o_err
);
    localparam int unsigned CntW = $clog2(NUM_COEFF + 1);
    localparam int unsigned BusW = NUM_COEFF * NBT_COEFF;

    if (NBF_COEFF >= NBT_COEFF) begin : g_bad_fmt
        $error("NBF_COEFF must be smaller than NBT_COEFF");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StFull, StSwap, StFlush} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] flush_q, flush_d;
    logic [BusW-1:0] shadow_q, shadow_d;
    logic [BusW-1:0] active_q, active_d;
    logic            err_q, err_d;
    logic            wr_ready, wr_fire, last_idx, len_err;
    logic            fir_en, fir_flush, busy;

    assign wr_fire  = host.i_wr_valid & wr_ready;
    // cnt is always zero in StIdle, so one compare covers both accepting states
    assign last_idx = (cnt_q == CntW'(NUM_COEFF - 1));

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_err = 1'b0;
        unique case (state_q)
            StIdle, StLoad: begin
                if (wr_fire) begin
                    if (last_idx && host.i_wr_last) begin
                        state_d = StFull;
                    end else if (last_idx || host.i_wr_last) begin
                        state_d = StIdle;
                        len_err = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StFull:  if (host.i_commit) state_d = StSwap;
            StSwap:  state_d = StFlush;
            StFlush: if (flush_q == CntW'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ready  = 1'b0;
        fir_en    = 1'b0;
        fir_flush = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                wr_ready = 1'b1;
                fir_en   = i_en;
                busy     = 1'b0;
            end
            StLoad: begin
                wr_ready = 1'b1;
                fir_en   = i_en;
            end
            StFull:  fir_en = i_en;
            StSwap:  ;
            StFlush: fir_flush = 1'b1;
            default: ;
        endcase
    end

    // Reset gating keeps the host and FIR quiet while reset is held
    assign host.o_wr_ready = wr_ready & i_reset_n;
    assign o_fir_en        = fir_en & i_reset_n;
    assign o_fir_flush     = fir_flush;
    assign o_busy          = busy;
    assign o_err           = err_q;
    assign o_coeff_bus     = active_q;

    always_comb begin
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = err_q;
        if (wr_fire) begin
            for (int unsigned k = 0; k < NUM_COEFF; k++) begin
                if (cnt_q == CntW'(k)) shadow_d[k*NBT_COEFF +: NBT_COEFF] = host.i_wr_data;
            end
            cnt_d = len_err ? '0 : cnt_q + CntW'(1);
        end
        if (state_q == StSwap) begin
            active_d = shadow_q;
            flush_d  = CntW'(NUM_COEFF);
        end
        if (state_q == StFlush) begin
            flush_d = flush_q - CntW'(1);
            if (flush_q == CntW'(1)) cnt_d = '0;
        end
        if (len_err) begin
            err_d = 1'b1;
        end else if (host.i_err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q    <= '0;
            flush_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: table-driven error/ignore vectors plus hand sequences for
// nominal swap, backpressure and reset during flush.
module tb_fir_coeff_ctrl;
    localparam int unsigned N    = 17;
    localparam int unsigned W    = 8;
    localparam int unsigned BusW = N * W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [BusW-1:0] coeff;
    logic            fir_en, flush, busy, err;

    int errors = 0;
    int checks = 0;

    fir_coeff_ctrl_if #(.NBT_COEFF(W)) h ();

    fir_coeff_ctrl #(
        .NUM_COEFF(N),
        .NBT_COEFF(W),
        .NBF_COEFF(7)
    ) dut (
        .clk        (clk),
        .i_reset_n  (rst_n),
        .i_en       (en),
        .host       (h),
        .o_coeff_bus(coeff),
        .o_fir_en   (fir_en),
        .o_fir_flush(flush),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       commit;
        logic       clr;
        logic       en;
        logic       exp_ready;
        logic       exp_busy;
        logic       exp_err;
        logic       exp_fir_en;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic c, input logic clr, input logic e,
                                input logic rdy, input logic bsy, input logic er,
                                input logic fe);
        vec_t r;
        r.valid = v; r.data = d; r.last = l; r.commit = c; r.clr = clr; r.en = e;
        r.exp_ready = rdy; r.exp_busy = bsy; r.exp_err = er; r.exp_fir_en = fe;
        return r;
    endfunction

    function automatic logic [BusW-1:0] exp_bus(input logic [7:0] base);
        logic [BusW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = base + 8'(k);
        return r;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BusW-1:0] act,
                           input logic [BusW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] base, input int n, input bit last_end);
        for (int k = 0; k < n; k++) begin
            h.i_wr_valid = 1'b1;
            h.i_wr_data  = base + 8'(k);
            h.i_wr_last  = last_end && (k == n - 1);
            step();
        end
        h.i_wr_valid = 1'b0;
        h.i_wr_last  = 1'b0;
    endtask

    task automatic commit_flush(input string nm, input logic [BusW-1:0] old_bus,
                                input logic [BusW-1:0] new_bus);
        int lo = 0;
        int fl = 0;
        int n  = 0;
        h.i_commit = 1'b1;
        step();
        h.i_commit = 1'b0;
        chk_bus({nm, "_bus_at_commit_edge"}, coeff, old_bus);
        chk_bit({nm, "_busy_swap"}, busy, 1'b1);
        if (!fir_en) lo++;
        if (flush) fl++;
        step();
        chk_bus({nm, "_bus_after_swap"}, coeff, new_bus);
        while (busy && n < 60) begin
            if (!fir_en) lo++;
            if (flush) fl++;
            step();
            n++;
        end
        chk_bit({nm, "_idle_after_flush"}, busy, 1'b0);
        chk_int({nm, "_fir_en_low_cycles"}, lo, N + 1);
        chk_int({nm, "_flush_cycles"}, fl, N);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BusW-1:0] b;
        int fl;
        rst_n = 1'b0;
        en = 1'b1;
        h.i_wr_valid = 1'b0;
        h.i_wr_data  = '0;
        h.i_wr_last  = 1'b0;
        h.i_commit   = 1'b0;
        h.i_err_clr  = 1'b0;

        // Reset held across a clock edge, sampled mid-cycle
        #23;
        chk_bus("rst_bus", coeff, '0);
        chk_bit("rst_fir_en", fir_en, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_err", err, 1'b0);
        chk_bit("rst_flush", flush, 1'b0);
        chk_bit("rst_ready", h.o_wr_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_bit("post_rst_ready", h.o_wr_ready, 1'b1);
        chk_bit("post_rst_fir_en", fir_en, 1'b1);

        // Nominal 17-tap load and commit
        load(8'h01, N, 1'b1);
        chk_bit("nom_full_busy", busy, 1'b1);
        chk_bit("nom_full_ready", h.o_wr_ready, 1'b0);
        chk_bit("nom_full_err", err, 1'b0);
        chk_bus("nom_full_bus_old", coeff, '0);
        step();
        step();
        commit_flush("nom", '0, exp_bus(8'h01));

        // Length errors, ignored commits, err_clr precedence
        for (int k = 0; k < 4; k++) vt.push_back(mk(1, 8'h30 + 8'(k), 0, 0, 0, 1, 1, 1, 0, 1));
        vt.push_back(mk(1, 8'h34, 1, 0, 0, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 1));
        for (int k = 0; k < N - 1; k++) vt.push_back(mk(1, 8'h50 + 8'(k), 0, 0, 0, 1, 1, 1, 0, 1));
        vt.push_back(mk(1, 8'h60, 0, 0, 0, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 1, 0, 1, 1, 0, 1, 1));
        vt.push_back(mk(1, 8'h77, 1, 0, 1, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 1));
        for (int i = 0; i < vt.size(); i++) begin
            h.i_wr_valid = vt[i].valid;
            h.i_wr_data  = vt[i].data;
            h.i_wr_last  = vt[i].last;
            h.i_commit   = vt[i].commit;
            h.i_err_clr  = vt[i].clr;
            en           = vt[i].en;
            step();
            chk_bit($sformatf("vec%0d_ready", i), h.o_wr_ready, vt[i].exp_ready);
            chk_bit($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
            chk_bit($sformatf("vec%0d_err", i), err, vt[i].exp_err);
            chk_bit($sformatf("vec%0d_fir_en", i), fir_en, vt[i].exp_fir_en);
        end
        h.i_wr_valid = 1'b0;
        h.i_wr_last  = 1'b0;
        h.i_commit   = 1'b0;
        h.i_err_clr  = 1'b0;
        en           = 1'b1;
        chk_bus("err_bus_unchanged", coeff, exp_bus(8'h01));

        // Backpressure in FULL, then the held word becomes tap 0 of the next load
        load(8'h40, N, 1'b1);
        chk_bit("bp_full_busy", busy, 1'b1);
        h.i_wr_valid = 1'b1;
        h.i_wr_data  = 8'h7F;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_bit($sformatf("bp_ready_%0d", i), h.o_wr_ready, 1'b0);
        end
        commit_flush("bp", exp_bus(8'h01), exp_bus(8'h40));
        step();
        chk_bit("bp_held_word_accepted", busy, 1'b1);
        h.i_wr_valid = 1'b0;
        load(8'h61, N - 1, 1'b1);
        chk_bit("bp_reload_full", h.o_wr_ready, 1'b0);
        b = exp_bus(8'h60);
        b[7:0] = 8'h7F;
        commit_flush("bp2", exp_bus(8'h40), b);

        // Reset asserted during flush cycle 8
        load(8'h10, N, 1'b1);
        h.i_commit = 1'b1;
        step();
        h.i_commit = 1'b0;
        fl = 0;
        for (int i = 0; i < 40 && fl < 8; i++) begin
            step();
            if (flush) fl++;
        end
        chk_int("rf_reached_flush8", fl, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bus("rf_bus", coeff, '0);
        chk_bit("rf_flush", flush, 1'b0);
        chk_bit("rf_busy", busy, 1'b0);
        chk_bit("rf_fir_en", fir_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_bit("rf_idle_busy", busy, 1'b0);
        chk_bit("rf_idle_ready", h.o_wr_ready, 1'b1);
        chk_bit("rf_idle_fir_en", fir_en, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
